uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clk_freq, default 50000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 115200, serial bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; asserting it low clears all state immediately.
REQ-005 Port rx_in  input  1  asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-006 Port rx_enable  input  1  receiver enable; when low, no frame is started and any frame in progress is aborted.
REQ-007 Port uld_rx_data  input  1  unload strobe from the consumer; one-cycle pulse acknowledges rx_data.
REQ-008 Port rx_data  output  8  last good received byte.
REQ-009 Port rx_empty  output  1  high when no unread byte is held.
REQ-010 Port rx_frame_err  output  1  sticky flag; last frame had a low stop bit.
REQ-011 Port rx_overrun  output  1  sticky flag; a byte was overwritten before it was unloaded.
REQ-012 Port rx_busy  output  1  high while the FSM is not in IDLE.

Function
REQ-013 rx_in passes through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value (rxs).
REQ-014 Oversample divisor DIV = clk_freq/(16*baud_rate), integer truncation; a tick is one clk cycle when the divider count equals DIV-1; the count then wraps to 0.
REQ-015 The divider and the 4-bit tick counter are held at 0 in IDLE, so sampling phase is aligned to the detected start edge.
REQ-016 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-017 IDLE -> START when rx_enable=1 and rxs=0.
REQ-018 START: on the 8th tick (tick count 7), if rxs=0 -> DATA with tick count cleared; if rxs=1 -> IDLE (glitch rejected, no flags change).
REQ-019 DATA: rxs sampled on every 16th tick; bits shift in LSB first; after bit 7 is sampled -> STOP.
REQ-020 STOP: rxs sampled on the 16th tick; if rxs=1: rx_data <= shift register, rx_empty <= 0, rx_frame_err <= 0, rx_overrun <= 1 if rx_empty was 0; then -> IDLE.
REQ-021 STOP with rxs=0: rx_frame_err <= 1, rx_data and rx_empty unchanged, byte discarded; then -> WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE when rxs=1 (a break condition does not generate frames).
REQ-023 uld_rx_data=1 sets rx_empty <= 1 and clears rx_overrun; no effect on rx_data or rx_frame_err.
REQ-024 uld_rx_data in the same cycle as a good stop-bit sample: the new byte wins; rx_empty=0, rx_overrun=0.
REQ-025 rx_enable falling in any non-IDLE state -> IDLE on the next clk; partial byte discarded; outputs unchanged.
REQ-026 Latency: rx_empty falls one clk after the stop-bit sample tick; start detection lags rx_in by 2 clk (synchronizer).
REQ-027 rx_busy = (state != IDLE), combinational from the state register.

Reset
REQ-028 On reset low: state=IDLE, divider=0, tick count=0, shift register=0, rx_data=8'h00, rx_empty=1, rx_frame_err=0, rx_overrun=0, rx_busy=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame aborts the frame; after release the receiver waits for a fresh falling edge on rxs.

Verification (clk_freq=1000000, baud_rate=62500, so DIV=1 and 16 clk per bit)
REQ-030 Send frame 0xA5 with rx_enable=1 -> rx_data=0xA5, rx_empty=0, rx_frame_err=0 about 9.5 bit times after the start edge; uld_rx_data pulse -> rx_empty=1.
REQ-031 Drive rx_in low for 4 clk and then high -> FSM returns to IDLE, rx_empty stays 1, and no flags change.
REQ-032 Send 0x3C with the stop bit held low, then release high -> rx_frame_err=1, rx_empty=1, rx_data unchanged; a following good 0x11 -> rx_data=0x11, rx_frame_err=0.
REQ-033 Send 0x01 then 0x02 with no unload -> rx_data=0x02, rx_overrun=1; uld_rx_data -> rx_overrun=0, rx_empty=1.
REQ-034 Assert reset low during bit 3 of a frame -> all outputs return to reset values immediately; a later frame 0x7E is received correctly.
REQ-035 Deassert rx_enable during bit 5 -> rx_busy=0 on the next clk and rx_empty stays 1; with rx_enable held low, a full frame is ignored.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, 16x oversampling, mid-bit sampling,
//                single-byte holding register with frame/overrun flags.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_enable,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int c_div   = clk_freq / (16 * baud_rate);
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               w_rxs;
    logic [c_div_w-1:0] r_div;
    logic [3:0]         r_tick_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_empty;
    logic               r_rx_frame_err;
    logic               r_rx_overrun;
    logic               w_tick;
    logic               w_start_done;
    logic               w_sample_bit;
    logic               w_stop_good;
    logic               w_stop_bad;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_div == c_div_last);

    // rx_in is asynchronous to clk; sync flops reset to the idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_done = 1'b0;
        w_sample_bit = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;
        if ((r_state != S_IDLE) && !rx_enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_enable && !w_rxs) begin
                        w_next_state = S_START;
                    end
                end
                S_START: begin
                    // half a bit into the start bit: confirm it is still low
                    if (w_tick && (r_tick_cnt == 4'd7)) begin
                        w_start_done = 1'b1;
                        w_next_state = w_rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick && (r_tick_cnt == 4'd15)) begin
                        w_sample_bit = 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            w_next_state = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick && (r_tick_cnt == 4'd15)) begin
                        if (w_rxs) begin
                            w_stop_good  = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_stop_bad   = 1'b1;
                            w_next_state = S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rxs) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Counters sit at zero in IDLE so the sampling phase tracks the start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else if (r_state == S_IDLE) begin
            r_div      <= '0;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_start_done) begin
                r_tick_cnt <= 4'd0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end
            if (w_sample_bit) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {w_rxs, r_shift[7:1]};
            end
        end
    end

    // A byte landing in the same cycle as an unload takes precedence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data      <= 8'h00;
            r_rx_empty     <= 1'b1;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
        end else if (w_stop_good) begin
            r_rx_data      <= r_shift;
            r_rx_empty     <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= ~r_rx_empty & ~uld_rx_data;
        end else begin
            if (uld_rx_data) begin
                r_rx_empty   <= 1'b1;
                r_rx_overrun <= 1'b0;
            end
            if (w_stop_bad) begin
                r_rx_frame_err <= 1'b1;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_empty     = r_rx_empty;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_overrun   = r_rx_overrun;
    assign rx_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx at 16 clk per bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_bit_clk = 16;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic       rx_enable;
    logic       uld_rx_data;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic       prev_empty;

    logic [7:0] model_data;
    logic       model_empty;
    logic       model_overrun;
    logic       model_ferr;

    uart_rx #(
        .clk_freq  (1000000),
        .baud_rate (62500)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_enable    (rx_enable),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every good byte that turns rx_empty from 1 to 0 must match the queue head
    always @(negedge clk) begin
        if (prev_empty && !rx_empty && reset) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                chk("sb_ferr", {31'h0, rx_frame_err}, 32'h0);
            end
        end
        prev_empty = rx_empty;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        rx_in = v;
        wait_clk(c_bit_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_val);
        rx_in = 1'b1;
    endtask

    task automatic unload();
        uld_rx_data = 1'b1;
        wait_clk(1);
        uld_rx_data = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       ok;
        checks      = 0;
        errors      = 0;
        prev_empty  = 1'b1;
        reset       = 1'b0;
        rx_in       = 1'b1;
        rx_enable   = 1'b1;
        uld_rx_data = 1'b0;
        wait_clk(3);
        chk("rst_data",  {24'h0, rx_data}, 32'h00);
        chk("rst_empty", {31'h0, rx_empty}, 32'h1);
        chk("rst_ferr",  {31'h0, rx_frame_err}, 32'h0);
        chk("rst_ovr",   {31'h0, rx_overrun}, 32'h0);
        chk("rst_busy",  {31'h0, rx_busy}, 32'h0);
        reset = 1'b1;
        wait_clk(5);

        // good frame 0xA5
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clk(2);
        chk("a5_empty", {31'h0, rx_empty}, 32'h0);
        chk("a5_ferr",  {31'h0, rx_frame_err}, 32'h0);
        unload();
        chk("a5_unload_empty", {31'h0, rx_empty}, 32'h1);
        chk("a5_unload_data",  {24'h0, rx_data}, 32'hA5);

        // short low glitch is rejected
        rx_in = 1'b0;
        wait_clk(4);
        chk("glitch_busy_mid", {31'h0, rx_busy}, 32'h1);
        rx_in = 1'b1;
        wait_clk(20);
        chk("glitch_busy",  {31'h0, rx_busy}, 32'h0);
        chk("glitch_empty", {31'h0, rx_empty}, 32'h1);
        chk("glitch_ferr",  {31'h0, rx_frame_err}, 32'h0);
        chk("glitch_ovr",   {31'h0, rx_overrun}, 32'h0);

        // framing error then recovery
        send_frame(8'h3C, 1'b0);
        wait_clk(8);
        chk("ferr_flag",  {31'h0, rx_frame_err}, 32'h1);
        chk("ferr_empty", {31'h0, rx_empty}, 32'h1);
        chk("ferr_data",  {24'h0, rx_data}, 32'hA5);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_clk(2);
        chk("rec_data", {24'h0, rx_data}, 32'h11);
        chk("rec_ferr", {31'h0, rx_frame_err}, 32'h0);
        unload();

        // overrun
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        wait_clk(2);
        chk("ovr_first", {31'h0, rx_overrun}, 32'h0);
        send_frame(8'h02, 1'b1);
        wait_clk(2);
        chk("ovr_data",  {24'h0, rx_data}, 32'h02);
        chk("ovr_flag",  {31'h0, rx_overrun}, 32'h1);
        unload();
        chk("ovr_clr",   {31'h0, rx_overrun}, 32'h0);
        chk("ovr_empty", {31'h0, rx_empty}, 32'h1);

        // reset during bit 3
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx_in = 1'b0;
        wait_clk(8);
        chk("pre_rst_busy", {31'h0, rx_busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_data",  {24'h0, rx_data}, 32'h00);
        chk("mid_rst_empty", {31'h0, rx_empty}, 32'h1);
        chk("mid_rst_busy",  {31'h0, rx_busy}, 32'h0);
        chk("mid_rst_ovr",   {31'h0, rx_overrun}, 32'h0);
        rx_in = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(5);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_clk(2);
        chk("post_rst_data", {24'h0, rx_data}, 32'h7E);
        unload();

        // enable dropped during bit 5, then a whole frame with enable low
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        wait_clk(8);
        chk("pre_dis_busy", {31'h0, rx_busy}, 32'h1);
        rx_enable = 1'b0;
        wait_clk(1);
        chk("dis_busy",  {31'h0, rx_busy}, 32'h0);
        chk("dis_empty", {31'h0, rx_empty}, 32'h1);
        rx_in = 1'b1;
        wait_clk(20);
        send_frame(8'h55, 1'b1);
        wait_clk(4);
        chk("dis_frame_empty", {31'h0, rx_empty}, 32'h1);
        chk("dis_frame_busy",  {31'h0, rx_busy}, 32'h0);
        chk("dis_frame_data",  {24'h0, rx_data}, 32'h7E);
        rx_enable = 1'b1;
        wait_clk(5);

        // randomized traffic against a flag-level model
        model_data    = 8'h7E;
        model_empty   = 1'b1;
        model_overrun = 1'b0;
        model_ferr    = 1'b0;
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            if (ok) begin
                if (model_empty) exp_q.push_back(b);
                model_overrun = !model_empty;
                model_empty   = 1'b0;
                model_data    = b;
                model_ferr    = 1'b0;
            end else begin
                model_ferr = 1'b1;
            end
            send_frame(b, ok);
            wait_clk(4 + $urandom_range(0, 12));
            chk("rnd_data",  {24'h0, rx_data}, {24'h0, model_data});
            chk("rnd_empty", {31'h0, rx_empty}, {31'h0, model_empty});
            chk("rnd_ferr",  {31'h0, rx_frame_err}, {31'h0, model_ferr});
            chk("rnd_ovr",   {31'h0, rx_overrun}, {31'h0, model_overrun});
            if ($urandom_range(0, 1) == 1) begin
                unload();
                model_empty   = 1'b1;
                model_overrun = 1'b0;
                chk("rnd_uld_empty", {31'h0, rx_empty}, 32'h1);
            end
        end

        wait_clk(4);
        chk("sb_drain", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
